// File: rtl/idx_seq_pkg.sv
// Shared definitions for the index sequencer: FSM state encoding and default width.
package idx_seq_pkg;

   localparam int N_DEFAULT = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/idx_seq_if.sv
// Control and status bundle between a sweep controller and the index sequencer.
interface idx_seq_if
   import idx_seq_pkg::*;
#(
   parameter int N = N_DEFAULT
);
   logic         start;
   logic         stop;
   logic         en;
   logic         dir;
   logic         cont;
   logic [N-1:0] limit;
   logic [N-1:0] binary;
   logic         valid;
   logic         busy;
   logic         done;
   logic         wrap;

   modport master (
      output start, stop, en, dir, cont, limit,
      input  binary, valid, busy, done, wrap
   );

   modport slave (
      input  start, stop, en, dir, cont, limit,
      output binary, valid, busy, done, wrap
   );
endinterface

// File: rtl/idx_seq_b2oh.sv
// Binary to one-hot decoder placed downstream of the index sequencer.
module b2oh #(
   parameter int N = 3
) (
   input  logic [N-1:0]        binary_i,
   output logic [(1<<N)-1:0]   onehot_o
);
   always_comb begin
      onehot_o           = '0;
      onehot_o[binary_i] = 1'b1;
   end
endmodule

// File: rtl/idx_seq.sv
// Index sequencer: sweeps a registered N-bit index up or down to a latched limit,
// either once (ending in a done pulse) or continuously (with a wrap pulse per restart).
module idx_seq
   import idx_seq_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic     clk,
   input  logic     rst,
   idx_seq_if.slave bus
);

   localparam logic [N-1:0] ONE = N'(1);

   state_e       state_q, state_d;
   logic [N-1:0] bin_q,   bin_d;
   logic         valid_q, valid_d;
   logic         busy_q,  busy_d;
   logic         done_q,  done_d;
   logic         wrap_q,  wrap_d;
   logic         dir_q,   dir_d;
   logic         cont_q,  cont_d;
   logic [N-1:0] limit_q, limit_d;
   logic         at_end;
   logic         accept;

   function automatic logic [N-1:0] first_idx(input logic dir, input logic [N-1:0] lim);
      return dir ? lim : '0;
   endfunction

   function automatic logic [N-1:0] step_idx(input logic dir, input logic [N-1:0] cur);
      return dir ? (cur - ONE) : (cur + ONE);
   endfunction

   // Endpoint is judged only against the latched sweep parameters.
   assign at_end = dir_q ? (bin_q == '0) : (bin_q == limit_q);
   assign accept = bus.start && !bus.stop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         bin_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
         dir_q   <= 1'b0;
         cont_q  <= 1'b0;
         limit_q <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
         dir_q   <= dir_d;
         cont_q  <= cont_d;
         limit_q <= limit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
      dir_d   = dir_q;
      cont_d  = cont_q;
      limit_d = limit_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            if (accept) begin
               dir_d   = bus.dir;
               cont_d  = bus.cont;
               limit_d = bus.limit;
               bin_d   = first_idx(bus.dir, bus.limit);
               valid_d = 1'b1;
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            // Priority: stop, then restart, then stepping/endpoint handling.
            if (bus.stop) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end else if (bus.start) begin
               dir_d   = bus.dir;
               cont_d  = bus.cont;
               limit_d = bus.limit;
               bin_d   = first_idx(bus.dir, bus.limit);
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end else if (bus.en) begin
               if (!at_end) begin
                  bin_d = step_idx(dir_q, bin_q);
               end else if (cont_q) begin
                  bin_d  = first_idx(dir_q, limit_q);
                  wrap_d = 1'b1;
               end else begin
                  state_d = ST_DONE;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.binary = bin_q;
   assign bus.valid  = valid_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_idx_seq.sv
// Directed bench for idx_seq with a downstream b2oh decoder.
module tb_idx_seq;
   import idx_seq_pkg::*;

   localparam int N = 3;

   logic         clk;
   logic         rst;
   logic [7:0]   oh;
   int           checks;
   int           errors;

   idx_seq_if #(.N(N)) bus ();

   idx_seq #(.N(N)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   b2oh #(.N(N)) u_oh (
      .binary_i (bus.binary),
      .onehot_o (oh)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic d, input logic c, input logic [N-1:0] lim);
      bus.dir   = d;
      bus.cont  = c;
      bus.limit = lim;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (bus.binary !== 3'd0) begin errors++; $display("FAIL reset_binary got %0d exp 0", bus.binary); end
      checks++; if ({bus.valid, bus.busy, bus.done, bus.wrap} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {bus.valid, bus.busy, bus.done, bus.wrap}); end
      checks++; if (oh !== 8'h01) begin errors++; $display("FAIL reset_onehot got %h exp 01", oh); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_sweep_up();
      bus.en = 1'b1;
      go(1'b0, 1'b0, 3'd7);
      for (int i = 0; i < 8; i++) begin
         checks++; if (bus.binary !== 3'(i)) begin errors++; $display("FAIL up_binary[%0d] got %0d exp %0d", i, bus.binary, i); end
         checks++; if ({bus.valid, bus.busy, bus.done, bus.wrap} !== 4'b1100) begin errors++; $display("FAIL up_flags[%0d] got %b exp 1100", i, {bus.valid, bus.busy, bus.done, bus.wrap}); end
         checks++; if (oh !== (8'h01 << i)) begin errors++; $display("FAIL up_onehot[%0d] got %h exp %h", i, oh, 8'h01 << i); end
         tick();
      end
      checks++; if ({bus.valid, bus.busy, bus.done, bus.wrap} !== 4'b0010) begin errors++; $display("FAIL up_done_flags got %b exp 0010", {bus.valid, bus.busy, bus.done, bus.wrap}); end
      checks++; if (bus.binary !== 3'd7) begin errors++; $display("FAIL up_done_binary got %0d exp 7", bus.binary); end
      tick();
      checks++; if ({bus.valid, bus.busy, bus.done, bus.wrap} !== 4'b0000) begin errors++; $display("FAIL up_idle_flags got %b exp 0000", {bus.valid, bus.busy, bus.done, bus.wrap}); end
   endtask

   task automatic test_sweep_down_cont();
      logic [N-1:0] exp_b;
      bus.en = 1'b1;
      go(1'b1, 1'b1, 3'd5);
      // Parameters changed mid-sweep must be ignored.
      bus.limit = 3'd2;
      bus.dir   = 1'b0;
      bus.cont  = 1'b0;
      for (int k = 0; k < 7; k++) begin
         exp_b = (k < 6) ? 3'(5 - k) : 3'd5;
         checks++; if (bus.binary !== exp_b) begin errors++; $display("FAIL down_binary[%0d] got %0d exp %0d", k, bus.binary, exp_b); end
         checks++; if (bus.wrap !== (k == 6)) begin errors++; $display("FAIL down_wrap[%0d] got %b exp %b", k, bus.wrap, (k == 6)); end
         checks++; if ({bus.valid, bus.busy, bus.done} !== 3'b110) begin errors++; $display("FAIL down_flags[%0d] got %b exp 110", k, {bus.valid, bus.busy, bus.done}); end
         checks++; if (oh !== (8'h01 << exp_b)) begin errors++; $display("FAIL down_onehot[%0d] got %h exp %h", k, oh, 8'h01 << exp_b); end
         tick();
      end
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      checks++; if ({bus.valid, bus.busy, bus.done, bus.wrap} !== 4'b0000) begin errors++; $display("FAIL down_stop_flags got %b exp 0000", {bus.valid, bus.busy, bus.done, bus.wrap}); end
   endtask

   task automatic test_hold_and_stop();
      bus.en = 1'b1;
      go(1'b0, 1'b0, 3'd7);
      tick();
      tick();
      tick();
      checks++; if (bus.binary !== 3'd3) begin errors++; $display("FAIL hold_pre got %0d exp 3", bus.binary); end
      bus.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.binary !== 3'd3 || bus.valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL hold[%0d] got b=%0d v=%b y=%b exp b=3 v=1 y=1", i, bus.binary, bus.valid, bus.busy); end
      end
      bus.en = 1'b1;
      tick();
      checks++; if (bus.binary !== 3'd4) begin errors++; $display("FAIL hold_resume got %0d exp 4", bus.binary); end
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      checks++; if ({bus.valid, bus.busy, bus.done, bus.wrap} !== 4'b0000) begin errors++; $display("FAIL stop_flags got %b exp 0000", {bus.valid, bus.busy, bus.done, bus.wrap}); end
      checks++; if (bus.binary !== 3'd4) begin errors++; $display("FAIL stop_binary got %0d exp 4", bus.binary); end
      tick();
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL stop_after got d=%b y=%b exp 0 0", bus.done, bus.busy); end
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin errors++; $display("FAIL start_stop_idle got y=%b v=%b exp 0 0", bus.busy, bus.valid); end
   endtask

   task automatic test_restart_and_done_start();
      bus.en = 1'b1;
      go(1'b0, 1'b0, 3'd7);
      tick();
      tick();
      checks++; if (bus.binary !== 3'd2) begin errors++; $display("FAIL restart_pre got %0d exp 2", bus.binary); end
      go(1'b1, 1'b0, 3'd4);
      checks++; if (bus.binary !== 3'd4 || {bus.valid, bus.busy, bus.done, bus.wrap} !== 4'b1100) begin errors++; $display("FAIL restart got b=%0d f=%b exp b=4 f=1100", bus.binary, {bus.valid, bus.busy, bus.done, bus.wrap}); end
      tick();
      checks++; if (bus.binary !== 3'd3) begin errors++; $display("FAIL restart_step got %0d exp 3", bus.binary); end
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      go(1'b0, 1'b0, 3'd1);
      tick();
      tick();
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL done_state got %b exp 1", bus.done); end
      go(1'b0, 1'b0, 3'd2);
      checks++; if (bus.binary !== 3'd0 || {bus.valid, bus.busy, bus.done, bus.wrap} !== 4'b1100) begin errors++; $display("FAIL done_start got b=%0d f=%b exp b=0 f=1100", bus.binary, {bus.valid, bus.busy, bus.done, bus.wrap}); end
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
   endtask

   task automatic test_reset_mid();
      bus.en = 1'b1;
      go(1'b0, 1'b1, 3'd7);
      for (int i = 0; i < 6; i++) tick();
      checks++; if (bus.binary !== 3'd6) begin errors++; $display("FAIL rstmid_pre got %0d exp 6", bus.binary); end
      rst = 1'b1;
      tick();
      checks++; if (bus.binary !== 3'd0 || {bus.valid, bus.busy, bus.done, bus.wrap} !== 4'b0000) begin errors++; $display("FAIL rstmid got b=%0d f=%b exp b=0 f=0000", bus.binary, {bus.valid, bus.busy, bus.done, bus.wrap}); end
      bus.start = 1'b1;
      tick();
      checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin errors++; $display("FAIL rst_start got y=%b v=%b exp 0 0", bus.busy, bus.valid); end
      bus.start = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_limit_zero();
      bus.en = 1'b1;
      go(1'b0, 1'b0, 3'd0);
      checks++; if (bus.binary !== 3'd0 || {bus.valid, bus.done} !== 2'b10) begin errors++; $display("FAIL lim0_first got b=%0d vd=%b exp b=0 vd=10", bus.binary, {bus.valid, bus.done}); end
      tick();
      checks++; if ({bus.valid, bus.busy, bus.done} !== 3'b001) begin errors++; $display("FAIL lim0_done got %b exp 001", {bus.valid, bus.busy, bus.done}); end
      tick();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL lim0_idle got %b exp 0", bus.done); end
      go(1'b1, 1'b1, 3'd0);
      checks++; if (bus.binary !== 3'd0 || {bus.valid, bus.wrap} !== 2'b10) begin errors++; $display("FAIL lim0c_first got b=%0d vw=%b exp b=0 vw=10", bus.binary, {bus.valid, bus.wrap}); end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (bus.binary !== 3'd0 || {bus.valid, bus.wrap, bus.done} !== 3'b110) begin errors++; $display("FAIL lim0c[%0d] got b=%0d vwd=%b exp b=0 vwd=110", i, bus.binary, {bus.valid, bus.wrap, bus.done}); end
      end
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.en    = 1'b0;
      bus.dir   = 1'b0;
      bus.cont  = 1'b0;
      bus.limit = '0;
      test_reset();
      test_sweep_up();
      test_sweep_down_cont();
      test_hold_and_stop();
      test_restart_and_done_start();
      test_reset_mid();
      test_limit_zero();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
